// File: rtl/adc_vd_sampler.sv
`default_nettype none
// ============================================================================
//  Module   : adc_vd_sampler
//  Purpose  : Serial-ADC front end for the PSU voltage loop. Drives an 8-bit
//             SPI ADC (CPOL=1, MSB first, padding bits around the data),
//             averages 2**AVG_LOG2 frames and publishes the result on cur_vd
//             with a one-cycle vd_valid strobe. cur_vd feeds the cur_vd
//             input of PID_controller.
//  Ports    : clk       in   system clock, all logic on posedge
//             n_rst     in   synchronous active-low reset
//             en        in   conversion enable
//             adc_sdata in   ADC serial data out
//             adc_cs_n  out  ADC chip select, active low
//             adc_sclk  out  ADC serial clock, idles high
//             cur_vd    out  averaged voltage word, held between updates
//             vd_valid  out  1-cycle pulse when cur_vd updates
//             busy      out  high while adc_cs_n is low
//  Revision : 1.0  initial release
// ============================================================================
module adc_vd_sampler #(
  parameter int ADC_WIDTH  = 8,
  parameter int FRAME_BITS = 16,
  parameter int LEAD_BITS  = 3,
  parameter int CLK_DIV    = 2,
  parameter int QUIET_CYC  = 4,
  parameter int AVG_LOG2   = 2
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 en,
  input  logic                 adc_sdata,
  output logic                 adc_cs_n,
  output logic                 adc_sclk,
  output logic [ADC_WIDTH-1:0] cur_vd,
  output logic                 vd_valid,
  output logic                 busy
);

  // One tick counter serves both the SCLK divider (CONV) and the
  // inter-frame gap (QUIET), so it is sized for the larger of the two.
  localparam int c_TICK_MAX = (CLK_DIV > QUIET_CYC) ? CLK_DIV : QUIET_CYC;
  localparam int c_TICK_W   = $clog2(c_TICK_MAX + 1);
  localparam int c_BIT_W    = $clog2(FRAME_BITS + 1);
  localparam int c_CNT_W    = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam int c_ACC_W    = ADC_WIDTH + AVG_LOG2;

  localparam logic [c_TICK_W-1:0] c_DIV_LAST   = c_TICK_W'(CLK_DIV - 1);
  localparam logic [c_TICK_W-1:0] c_QUIET_LAST = c_TICK_W'(QUIET_CYC - 1);
  localparam logic [c_BIT_W-1:0]  c_BIT_LAST   = c_BIT_W'(FRAME_BITS - 1);
  localparam logic [c_BIT_W-1:0]  c_DATA_FIRST = c_BIT_W'(LEAD_BITS);
  localparam logic [c_BIT_W-1:0]  c_DATA_END   = c_BIT_W'(LEAD_BITS + ADC_WIDTH);
  localparam logic [c_CNT_W-1:0]  c_CNT_LAST   = c_CNT_W'((1 << AVG_LOG2) - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CONV  = 2'd1,
    S_QUIET = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic [c_TICK_W-1:0]   r_tick;
  logic [c_BIT_W-1:0]    r_bit;
  logic [ADC_WIDTH-1:0]  r_shift;
  logic [c_ACC_W-1:0]    r_acc;
  logic [c_CNT_W-1:0]    r_cnt;
  logic                  r_cs_n;
  logic                  r_sclk;
  logic [ADC_WIDTH-1:0]  r_cur_vd;
  logic                  r_vd_valid;

  logic                  w_div_last;
  logic                  w_rise;
  logic                  w_frame_done;
  logic                  w_quiet_done;
  logic                  w_in_window;
  logic [ADC_WIDTH-1:0]  w_shift_in;
  logic [ADC_WIDTH-1:0]  w_shift_next;
  logic [c_ACC_W-1:0]    w_sum;
  logic [ADC_WIDTH-1:0]  w_avg;
  logic                  w_avg_done;

  assign w_div_last   = (r_tick == c_DIV_LAST);
  // A rise is a terminal-count toggle while SCLK is currently low.
  assign w_rise       = (r_state == S_CONV) && w_div_last && !r_sclk;
  assign w_frame_done = w_rise && (r_bit == c_BIT_LAST);
  assign w_quiet_done = (r_state == S_QUIET) && (r_tick == c_QUIET_LAST);
  assign w_in_window  = (r_bit >= c_DATA_FIRST) && (r_bit < c_DATA_END);

  generate
    if (ADC_WIDTH > 1) begin : g_shift_wide
      assign w_shift_in = {r_shift[ADC_WIDTH-2:0], adc_sdata};
    end else begin : g_shift_one
      assign w_shift_in = adc_sdata;
    end
  endgenerate

  // The word used at frame end includes a bit captured on that same edge,
  // which matters when the last data bit is also the last frame bit.
  assign w_shift_next = (w_rise && w_in_window) ? w_shift_in : r_shift;
  assign w_sum        = r_acc + c_ACC_W'(w_shift_next);
  assign w_avg        = ADC_WIDTH'(w_sum >> AVG_LOG2);
  assign w_avg_done   = (r_cnt == c_CNT_LAST);

  always_ff @(posedge clk) begin
    if (!n_rst) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  // en is only looked at in IDLE and on the final QUIET cycle, so a frame
  // once started always runs to completion.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (en)           w_state_next = S_CONV;
      S_CONV:  if (w_frame_done) w_state_next = S_QUIET;
      S_QUIET: if (w_quiet_done) w_state_next = en ? S_CONV : S_IDLE;
      default:                   w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      r_tick     <= '0;
      r_bit      <= '0;
      r_shift    <= '0;
      r_acc      <= '0;
      r_cnt      <= '0;
      r_cs_n     <= 1'b1;
      r_sclk     <= 1'b1;
      r_cur_vd   <= '0;
      r_vd_valid <= 1'b0;
    end else begin
      r_vd_valid <= 1'b0;
      r_cs_n     <= (w_state_next != S_CONV);
      r_shift    <= w_shift_next;
      case (r_state)
        S_IDLE: begin
          r_tick <= '0;
          r_bit  <= '0;
          r_sclk <= 1'b1;
          r_acc  <= '0;
          r_cnt  <= '0;
        end
        S_CONV: begin
          if (w_div_last) begin
            r_tick <= '0;
            r_sclk <= ~r_sclk;
          end else begin
            r_tick <= r_tick + 1'b1;
          end
          if (w_rise) r_bit <= w_frame_done ? '0 : r_bit + 1'b1;
          if (w_frame_done) begin
            if (w_avg_done) begin
              r_cur_vd   <= w_avg;
              r_vd_valid <= 1'b1;
              r_acc      <= '0;
              r_cnt      <= '0;
            end else begin
              r_acc <= w_sum;
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        S_QUIET: begin
          r_sclk <= 1'b1;
          r_bit  <= '0;
          if (w_quiet_done) begin
            r_tick <= '0;
            // Falling back to IDLE throws away any partial average.
            if (!en) begin
              r_acc <= '0;
              r_cnt <= '0;
            end
          end else begin
            r_tick <= r_tick + 1'b1;
          end
        end
        default: begin
          r_tick <= '0;
          r_bit  <= '0;
          r_sclk <= 1'b1;
        end
      endcase
    end
  end

  assign adc_cs_n = r_cs_n;
  assign adc_sclk = r_sclk;
  assign cur_vd   = r_cur_vd;
  assign vd_valid = r_vd_valid;
  assign busy     = ~r_cs_n;

endmodule
`default_nettype wire

// File: tb/tb_adc_vd_sampler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_adc_vd_sampler
//  Purpose  : Self-checking bench for adc_vd_sampler. Two instances share
//             clk/n_rst: dut0 with AVG_LOG2=0 and dut2 with AVG_LOG2=2.
//             Each has a behavioural ADC that shifts on SCLK falls and
//             drives 1 on every padding bit.
//  Revision : 1.0  initial release
// ============================================================================
module tb_adc_vd_sampler;

  localparam int c_LEAD = 3;
  localparam int c_W    = 8;

  logic       clk;
  logic       n_rst;
  logic       en0, en2;
  logic       sd0, sd2;
  logic       cs0, cs2, sclk0, sclk2, vd0, vd2, busy0, busy2;
  logic [7:0] cur0, cur2;

  adc_vd_sampler #(.AVG_LOG2(0)) dut0 (
    .clk(clk), .n_rst(n_rst), .en(en0), .adc_sdata(sd0),
    .adc_cs_n(cs0), .adc_sclk(sclk0), .cur_vd(cur0), .vd_valid(vd0), .busy(busy0)
  );

  adc_vd_sampler #(.AVG_LOG2(2)) dut2 (
    .clk(clk), .n_rst(n_rst), .en(en2), .adc_sdata(sd2),
    .adc_cs_n(cs2), .adc_sclk(sclk2), .cur_vd(cur2), .vd_valid(vd2), .busy(busy2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // ---------------- behavioural ADC models ----------------
  logic [7:0] q0[$];
  logic [7:0] q2[$];
  logic [7:0] m0_word = 8'h00, m2_word = 8'h00;
  int         m0_bit = 0, m2_bit = 0;

  function automatic logic bitval(input logic [7:0] w, input int j);
    if (j >= c_LEAD && j < c_LEAD + c_W) return w[c_LEAD + c_W - 1 - j];
    return 1'b1;
  endfunction

  initial begin
    sd0 = 1'b1;
    sd2 = 1'b1;
  end

  always @(negedge cs0) begin
    m0_word = (q0.size() > 0) ? q0.pop_front() : 8'h00;
    m0_bit  = 0;
    sd0     = 1'b1;
  end
  always @(negedge sclk0) if (!cs0) begin
    sd0 = bitval(m0_word, m0_bit);
    m0_bit++;
  end

  always @(negedge cs2) begin
    m2_word = (q2.size() > 0) ? q2.pop_front() : 8'h00;
    m2_bit  = 0;
    sd2     = 1'b1;
  end
  always @(negedge sclk2) if (!cs2) begin
    sd2 = bitval(m2_word, m2_bit);
    m2_bit++;
  end

  // ---------------- monitors (sampled on negedge) ----------------
  int   low0 = 0, high0 = 0, last_low0 = 0, last_high0 = 0, rises0 = 0, last_rises0 = 0;
  int   falls0 = 0, vcount0 = 0, viol0 = 0;
  logic pcs0 = 1'b1, psclk0 = 1'b1;
  int   low2 = 0, high2 = 0, last_low2 = 0, last_high2 = 0, rises2 = 0, last_rises2 = 0;
  int   falls2 = 0, vcount2 = 0, viol2 = 0;
  logic pcs2 = 1'b1, psclk2 = 1'b1;

  always @(negedge clk) begin
    if (pcs0 && !cs0) begin falls0++; rises0 = 0; if (high0 > 0) last_high0 = high0; high0 = 0; end
    if (!psclk0 && sclk0) rises0++;
    if (!pcs0 && cs0) begin last_low0 = low0; last_rises0 = rises0; low0 = 0; end
    if (!cs0) low0++; else high0++;
    if (vd0) vcount0++;
    if (busy0 !== ~cs0) viol0++;
    if (vd0 && !cs0) viol0++;
    pcs0 = cs0; psclk0 = sclk0;

    if (pcs2 && !cs2) begin falls2++; rises2 = 0; if (high2 > 0) last_high2 = high2; high2 = 0; end
    if (!psclk2 && sclk2) rises2++;
    if (!pcs2 && cs2) begin last_low2 = low2; last_rises2 = rises2; low2 = 0; end
    if (!cs2) low2++; else high2++;
    if (vd2) vcount2++;
    if (busy2 !== ~cs2) viol2++;
    if (vd2 && !cs2) viol2++;
    pcs2 = cs2; psclk2 = sclk2;
  end

  // ---------------- helpers ----------------
  function automatic logic get_vd(input int sel);
    return (sel == 0) ? vd0 : vd2;
  endfunction
  function automatic logic get_cs(input int sel);
    return (sel == 0) ? cs0 : cs2;
  endfunction

  task automatic wait_valid(input int sel, input int budget, input string name);
    bit ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (get_vd(sel)) begin ok = 1'b1; break; end
    end
    #1;
    chk(name, int'(ok), 1);
  endtask

  task automatic wait_cs_low(input int sel, input int budget, input string name);
    bit ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (!get_cs(sel)) begin ok = 1'b1; break; end
    end
    #1;
    chk(name, int'(ok), 1);
  endtask

  typedef struct {
    logic [7:0] s;
    logic [7:0] exp;
  } single_t;

  typedef struct {
    logic [3:0][7:0] s;
    logic [7:0]      exp;
  } avg_t;

  function automatic single_t mk_single(input logic [7:0] s, input logic [7:0] e);
    single_t r;
    r.s = s; r.exp = e;
    return r;
  endfunction

  function automatic avg_t mk_avg(input logic [7:0] a, b, c, d, e);
    avg_t r;
    r.s = {d, c, b, a}; r.exp = e;
    return r;
  endfunction

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- test sequence ----------------
  initial begin
    single_t sv[6];
    avg_t    av[5];
    int      v, bad, f, prev_t, r, ps;
    bit      ok;

    sv[0] = mk_single(8'h00, 8'h00);
    sv[1] = mk_single(8'hFF, 8'hFF);
    sv[2] = mk_single(8'h5A, 8'h5A);
    sv[3] = mk_single(8'h80, 8'h80);
    sv[4] = mk_single(8'h01, 8'h01);
    sv[5] = mk_single(8'h3C, 8'h3C);

    av[0] = mk_avg(8'd10,  8'd11,  8'd12,  8'd14,  8'd11);   // 47>>2
    av[1] = mk_avg(8'd255, 8'd255, 8'd255, 8'd255, 8'd255);
    av[2] = mk_avg(8'd0,   8'd0,   8'd0,   8'd3,   8'd0);    // 3>>2
    av[3] = mk_avg(8'd1,   8'd2,   8'd3,   8'd5,   8'd2);    // 11>>2
    av[4] = mk_avg(8'd200, 8'd201, 8'd202, 8'd203, 8'd201);  // 806>>2

    // ---- 1: reset held with en high ----
    n_rst = 1'b0; en0 = 1'b1; en2 = 1'b0;
    q0.push_back(8'hA5);
    @(posedge clk);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (cs0 !== 1'b1 || sclk0 !== 1'b1 || cur0 !== 8'h00 || vd0 !== 1'b0) bad++;
      if (cs2 !== 1'b1 || sclk2 !== 1'b1 || cur2 !== 8'h00 || vd2 !== 1'b0) bad++;
    end
    chk("reset_hold_bad_cycles", bad, 0);
    chk("reset_busy0", int'(busy0), 0);
    v = vcount0;
    n_rst = 1'b1;
    @(posedge clk); #1;
    chk("cs_fall_after_reset", int'(cs0), 0);

    // ---- 2: single frame 0xA5, no averaging ----
    @(negedge clk);
    en0 = 1'b0;
    wait_valid(0, 100, "t2_wait_valid");
    chk("t2_cur_vd", int'(cur0), 8'hA5);
    chk("t2_cs_low_cycles", last_low0, 64);
    chk("t2_sclk_rises", last_rises0, 16);
    repeat (10) @(negedge clk);
    chk("t2_valid_count", vcount0 - v, 1);
    chk("t2_back_idle", int'(cs0), 1);

    // ---- single-frame table on dut0 ----
    for (int i = 0; i < 6; i++) begin
      q0.push_back(sv[i].s);
      v = vcount0;
      en0 = 1'b1;
      wait_cs_low(0, 20, $sformatf("single%0d_start", i));
      en0 = 1'b0;
      wait_valid(0, 100, $sformatf("single%0d_wait", i));
      chk($sformatf("single%0d_cur_vd", i), int'(cur0), int'(sv[i].exp));
      chk($sformatf("single%0d_low", i), last_low0, 64);
      repeat (10) @(negedge clk);
      chk($sformatf("single%0d_count", i), vcount0 - v, 1);
    end

    // ---- 3: averaging table on dut2 ----
    for (int i = 0; i < 5; i++) begin
      for (int k = 0; k < 4; k++) q2.push_back(av[i].s[k]);
      v = vcount2;
      en2 = 1'b1;
      wait_valid(2, 400, $sformatf("avg%0d_wait", i));
      en2 = 1'b0;
      chk($sformatf("avg%0d_cur_vd", i), int'(cur2), int'(av[i].exp));
      chk($sformatf("avg%0d_frames", i), falls2 >= 4 ? 1 : 0, 1);
      repeat (20) @(negedge clk);
      chk($sformatf("avg%0d_count", i), vcount2 - v, 1);
      chk($sformatf("avg%0d_idle", i), int'(cs2), 1);
    end

    // ---- 5: en dropped mid-frame 3, partial average discarded ----
    q2.push_back(8'd100); q2.push_back(8'd100); q2.push_back(8'd100);
    for (int k = 0; k < 4; k++) q2.push_back(8'd20);
    v = vcount2;
    f = falls2;
    en2 = 1'b1;
    ok = 1'b0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk); #1;
      if (falls2 == f + 3) begin ok = 1'b1; break; end
    end
    chk("t5_reach_frame3", int'(ok), 1);
    repeat (30) @(negedge clk);
    en2 = 1'b0;
    repeat (100) @(negedge clk);
    #1;
    chk("t5_no_valid_partial", vcount2 - v, 0);
    chk("t5_frame3_low", last_low2, 64);
    chk("t5_frame3_rises", last_rises2, 16);
    chk("t5_idle", int'(cs2), 1);
    chk("t5_frame_count", falls2 - f, 3);
    en2 = 1'b1;
    wait_valid(2, 400, "t5_wait_valid");
    en2 = 1'b0;
    chk("t5_cur_vd", int'(cur2), 20);
    repeat (20) @(negedge clk);
    chk("t5_valid_count", vcount2 - v, 1);

    // ---- 4: continuous ramp on dut0 ----
    for (int i = 0; i < 256; i++) q0.push_back(8'(i));
    en0 = 1'b1;
    prev_t = 0;
    bad = 0;
    for (int i = 0; i < 256; i++) begin
      wait_valid(0, 100, $sformatf("ramp%0d_wait", i));
      chk($sformatf("ramp%0d_cur_vd", i), int'(cur0), i);
      if (i > 0) begin
        chk($sformatf("ramp%0d_spacing", i), cyc - prev_t, 68);
        chk($sformatf("ramp%0d_cs_high", i), last_high0, 4);
      end
      prev_t = cyc;
    end
    en0 = 1'b0;
    repeat (20) @(negedge clk);
    chk("ramp_idle", int'(cs0), 1);

    // ---- 6: reset at SCLK rise 7, then clean capture ----
    q0.push_back(8'h33);
    q0.push_back(8'h77);
    v = vcount0;
    en0 = 1'b1;
    wait_cs_low(0, 20, "t6_start");
    r = 0;
    ps = int'(sclk0);
    for (int c = 0; c < 200 && r < 7; c++) begin
      @(posedge clk); #1;
      if (sclk0 && ps == 0) r++;
      ps = int'(sclk0);
    end
    chk("t6_reached_rise7", r, 7);
    n_rst = 1'b0;
    @(posedge clk); #1;
    chk("t6_cs_after_reset", int'(cs0), 1);
    chk("t6_sclk_after_reset", int'(sclk0), 1);
    chk("t6_cur_vd_cleared", int'(cur0), 0);
    chk("t6_no_valid", int'(vd0), 0);
    n_rst = 1'b1;
    wait_valid(0, 120, "t6_wait_valid");
    en0 = 1'b0;
    chk("t6_cur_vd", int'(cur0), 8'h77);
    chk("t6_clean_low", last_low0, 64);
    chk("t6_clean_rises", last_rises0, 16);
    repeat (10) @(negedge clk);
    chk("t6_valid_count", vcount0 - v, 1);

    chk("dut0_busy_valid_violations", viol0, 0);
    chk("dut2_busy_valid_violations", viol2, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
